// File: rtl/xdrop_extend_ctrl_if.sv
// Beat stream from the seed-hit source plus the scoring Selector side-channel.
// master = beat producer / Selector, slave = extension controller.
interface xdrop_extend_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] q_base;
  logic [1:0] s_base;
  logic       in_gap;
  logic       in_last;
  logic [2:0] sel;
  logic [1:0] sel_result;

  modport master (
    output in_valid,
    output q_base,
    output s_base,
    output in_gap,
    output in_last,
    output sel_result,
    input  in_ready,
    input  sel
  );

  modport slave (
    input  in_valid,
    input  q_base,
    input  s_base,
    input  in_gap,
    input  in_last,
    input  sel_result,
    output in_ready,
    output sel
  );
endinterface

// File: rtl/xdrop_extend_ctrl.sv
// Ungapped X-drop seed extension sequencer: drives the Selector one-hot per beat,
// accumulates a saturating running score and tracks the best score and its length.
module xdrop_extend_ctrl #(
  parameter int unsigned SCORE_W = 12,
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned XDROP   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic signed [SCORE_W-1:0] seed_score,
  xdrop_extend_ctrl_if.slave        beat_if,
  output logic                      busy,
  output logic                      done,
  output logic signed [SCORE_W-1:0] best_score,
  output logic [LEN_W-1:0]          best_len,
  output logic [1:0]                term_cause
);

  localparam int unsigned ExtW = SCORE_W + 1;
  localparam logic signed [ExtW-1:0] ScoreMax = {2'b00, {(SCORE_W-1){1'b1}}};
  localparam logic signed [ExtW-1:0] ScoreMin = {2'b11, {(SCORE_W-1){1'b0}}};
  localparam logic signed [ExtW-1:0] XdropExt = ExtW'(XDROP);

  localparam logic [1:0] CauseLast  = 2'b00;
  localparam logic [1:0] CauseXdrop = 2'b01;
  localparam logic [1:0] CauseLen   = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                     state_q, state_d;
  logic signed [SCORE_W-1:0]  score_q, score_d;
  logic signed [SCORE_W-1:0]  best_q, best_d;
  logic [LEN_W-1:0]           count_q, count_d;
  logic [LEN_W-1:0]           blen_q, blen_d;
  logic [1:0]                 cause_q, cause_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       fire;
  logic signed [ExtW-1:0]     sum_ext;
  logic signed [ExtW-1:0]     drop_ext;
  logic signed [SCORE_W-1:0]  nscore;
  logic signed [SCORE_W-1:0]  nbest;
  logic [LEN_W-1:0]           ncount;
  logic                       xdrop_hit;
  logic                       len_hit;

  assign fire = ready_q && beat_if.in_valid;

  // Selector one-hot; gap overrides the base comparison.
  always_comb begin
    beat_if.sel = 3'b000;
    if (fire) begin
      if (beat_if.in_gap) begin
        beat_if.sel = 3'b001;
      end else if (beat_if.q_base == beat_if.s_base) begin
        beat_if.sel = 3'b100;
      end else begin
        beat_if.sel = 3'b010;
      end
    end
  end

  // One extra bit of headroom so the saturation test sees the true sum.
  always_comb begin
    sum_ext = {score_q[SCORE_W-1], score_q}
            + {{(ExtW-2){beat_if.sel_result[1]}}, beat_if.sel_result};
    if (sum_ext > ScoreMax) begin
      nscore = ScoreMax[SCORE_W-1:0];
    end else if (sum_ext < ScoreMin) begin
      nscore = ScoreMin[SCORE_W-1:0];
    end else begin
      nscore = sum_ext[SCORE_W-1:0];
    end
  end

  always_comb begin
    ncount    = count_q + LEN_W'(1);
    nbest     = (nscore > best_q) ? nscore : best_q;
    drop_ext  = {nbest[SCORE_W-1], nbest} - {nscore[SCORE_W-1], nscore};
    xdrop_hit = (drop_ext >= XdropExt);
    len_hit   = &ncount;
  end

  always_comb begin
    state_d = state_q;
    score_d = score_q;
    best_d  = best_q;
    count_d = count_q;
    blen_d  = blen_q;
    cause_d = cause_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          score_d = seed_score;
          best_d  = seed_score;
          count_d = '0;
          blen_d  = '0;
          ready_d = 1'b1;
          busy_d  = 1'b1;
        end
      end
      StRun: begin
        if (fire) begin
          score_d = nscore;
          count_d = ncount;
          // Strict compare keeps the earliest length on ties.
          if (nscore > best_q) begin
            best_d = nscore;
            blen_d = ncount;
          end
          if (xdrop_hit || beat_if.in_last || len_hit) begin
            if (xdrop_hit) begin
              cause_d = CauseXdrop;
            end else if (beat_if.in_last) begin
              cause_d = CauseLast;
            end else begin
              cause_d = CauseLen;
            end
            state_d = StDone;
            ready_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        ready_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      score_q <= '0;
      best_q  <= '0;
      count_q <= '0;
      blen_q  <= '0;
      cause_q <= CauseLast;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      score_q <= score_d;
      best_q  <= best_d;
      count_q <= count_d;
      blen_q  <= blen_d;
      cause_q <= cause_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign beat_if.in_ready = ready_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign best_score       = best_q;
  assign best_len         = blen_q;
  assign term_cause       = cause_q;

  sel_onehot_a : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(beat_if.sel));
  done_not_ready_a : assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !beat_if.in_ready);

endmodule
